// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the frame FSM encoding and a width helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index
// scanning upward from last_i+1, wrapping onto last_i itself.
module uart_tx_arbiter_rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Rotating priority scan; the previous owner is checked last.
    always_comb begin
        int k;
        logic found;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        k        = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last_i) + i) % N;
            if (!found && valid_i[k]) begin
                found       = 1'b1;
                idx_o       = IW'(k);
                onehot_o[k] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter
// among NUM_REQ byte producers, with burst limit and idle gap.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int GAP_BITS   = 1,
    parameter int MAX_BURST  = 4,
    parameter int IW         = clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_sample_tick,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [IW-1:0]        grant_id,
    output logic                 busy
);

    localparam int GAP_TOT = GAP_BITS * OVERSAMPLE;
    localparam int GW      = clog2(GAP_TOT + 1);
    localparam int BW      = clog2(MAX_BURST);

    state_e          state_q;
    logic            tick_q;
    logic [IW-1:0]   last_q;
    logic [BW-1:0]   burst_q;
    logic [GW-1:0]   gap_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               cont;
    logic               tick_rise;
    logic [IW-1:0]      grant_d;
    logic [BW-1:0]      burst_d;
    logic [7:0]         data_d;

    uart_tx_arbiter_rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .valid_i  (req_valid),
        .last_i   (last_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign tick_rise = baud_sample_tick & ~tick_q;
    assign busy      = (state_q != S_IDLE);

    // Stay with the burst owner while it has data and budget left.
    always_comb begin
        cont    = (int'(burst_q) < MAX_BURST - 1) && req_valid[last_q];
        grant_d = cont ? last_q : pick_idx;
        burst_d = cont ? burst_q + 1'b1 : '0;
        data_d  = req_data[int'(grant_d)*8 +: 8];
    end

    // Accept strobe to the winner, only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == S_IDLE && pick_any) begin
            if (cont) begin
                req_ready[last_q] = 1'b1;
            end else begin
                req_ready = pick_oh;
            end
        end
    end

    // Frame FSM with data latch, burst and gap counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            last_q   <= IW'(NUM_REQ - 1);
            burst_q  <= '0;
            gap_q    <= '0;
        end else begin
            tick_q   <= baud_sample_tick;
            tx_start <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        tx_data  <= data_d;
                        grant_id <= grant_d;
                        last_q   <= grant_d;
                        burst_q  <= burst_d;
                        tx_start <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (GAP_TOT == 0) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (tick_rise) begin
                        if (int'(gap_q) == GAP_TOT - 1) begin
                            state_q <= S_IDLE;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A uses gap and
// burst 4, instance B has no gap and pure round robin.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_tick, b_tick;
    logic [3:0]  a_valid, b_valid, a_ready, b_ready;
    logic [31:0] a_data, b_data;
    logic        a_start, b_start, a_done, b_done;
    logic        a_busy, b_busy;
    logic [7:0]  a_txd, b_txd;
    logic [1:0]  a_gid, b_gid;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4), .OVERSAMPLE(16), .GAP_BITS(1), .MAX_BURST(4)
    ) u_a (
        .clk(clk), .rst(rst), .baud_sample_tick(a_tick),
        .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
        .tx_start(a_start), .tx_data(a_txd), .tx_done(a_done),
        .grant_id(a_gid), .busy(a_busy)
    );

    uart_tx_arbiter #(
        .NUM_REQ(4), .OVERSAMPLE(16), .GAP_BITS(0), .MAX_BURST(1)
    ) u_b (
        .clk(clk), .rst(rst), .baud_sample_tick(b_tick),
        .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
        .tx_start(b_start), .tx_data(b_txd), .tx_done(b_done),
        .grant_id(b_gid), .busy(b_busy)
    );

    typedef struct {
        bit         sel;
        logic [3:0] valid;
        logic [3:0] ready;
        logic [7:0] data;
        logic [1:0] gid;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rdy(input bit s);
        return s ? b_ready : a_ready;
    endfunction

    function automatic logic st(input bit s);
        return s ? b_start : a_start;
    endfunction

    function automatic logic [7:0] txd(input bit s);
        return s ? b_txd : a_txd;
    endfunction

    function automatic logic [1:0] gid(input bit s);
        return s ? b_gid : a_gid;
    endfunction

    task automatic tick_pulse();
        @(negedge clk);
        a_tick = 1'b1;
        @(negedge clk);
        a_tick = 1'b0;
    endtask

    task automatic finish_a();
        @(negedge clk);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        repeat (16) tick_pulse();
    endtask

    task automatic frame(input vec_t v);
        int w;
        @(negedge clk);
        if (v.sel) b_valid = v.valid;
        else       a_valid = v.valid;
        #1;
        w = 0;
        while (rdy(v.sel) == 4'd0 && w < 80) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("frame_ready", 32'(rdy(v.sel)), 32'(v.ready));
        @(negedge clk);
        if (v.sel) b_valid = '0;
        else       a_valid = '0;
        #1;
        chk("frame_start", 32'(st(v.sel)), 32'd1);
        chk("frame_data", 32'(txd(v.sel)), 32'(v.data));
        chk("frame_gid", 32'(gid(v.sel)), 32'(v.gid));
        @(negedge clk);
        #1;
        chk("frame_one_start", 32'(st(v.sel)), 32'd0);
        if (v.sel) b_done = 1'b1;
        else       a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        b_done = 1'b0;
        #1;
        if (v.sel) chk("nogap_idle", 32'(b_busy), 32'd0);
        else       repeat (16) tick_pulse();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 4'h1, 8'h10, 2'd0};
        tbl[1]  = '{1'b1, 4'hF, 4'h2, 8'h11, 2'd1};
        tbl[2]  = '{1'b1, 4'hF, 4'h4, 8'h12, 2'd2};
        tbl[3]  = '{1'b1, 4'hF, 4'h8, 8'h13, 2'd3};
        tbl[4]  = '{1'b1, 4'hF, 4'h1, 8'h10, 2'd0};
        tbl[5]  = '{1'b0, 4'h6, 4'h2, 8'h11, 2'd1};
        tbl[6]  = '{1'b0, 4'h6, 4'h2, 8'h11, 2'd1};
        tbl[7]  = '{1'b0, 4'h6, 4'h2, 8'h11, 2'd1};
        tbl[8]  = '{1'b0, 4'h6, 4'h2, 8'h11, 2'd1};
        tbl[9]  = '{1'b0, 4'h6, 4'h4, 8'h12, 2'd2};
        tbl[10] = '{1'b0, 4'h6, 4'h4, 8'h12, 2'd2};
        tbl[11] = '{1'b0, 4'h6, 4'h4, 8'h12, 2'd2};
        tbl[12] = '{1'b0, 4'h6, 4'h4, 8'h12, 2'd2};
        tbl[13] = '{1'b0, 4'h6, 4'h2, 8'h11, 2'd1};
        tbl[14] = '{1'b0, 4'h5, 4'h4, 8'h12, 2'd2};
        tbl[15] = '{1'b0, 4'h3, 4'h1, 8'h10, 2'd0};
        tbl[16] = '{1'b0, 4'h8, 4'h8, 8'h13, 2'd3};
        tbl[17] = '{1'b0, 4'h8, 4'h8, 8'h13, 2'd3};
        tbl[18] = '{1'b0, 4'h8, 4'h8, 8'h13, 2'd3};
        tbl[19] = '{1'b0, 4'h8, 4'h8, 8'h13, 2'd3};
        tbl[20] = '{1'b0, 4'h8, 4'h8, 8'h13, 2'd3};

        rst     = 1'b1;
        a_tick  = 1'b0;
        b_tick  = 1'b0;
        a_valid = '0;
        b_valid = '0;
        a_data  = '0;
        b_data  = 32'h13121110;
        a_done  = 1'b0;
        b_done  = 1'b0;

        repeat (3) @(negedge clk);
        a_valid = 4'h1;
        #1;
        chk("rst_ready_a", 32'(a_ready), 32'd0);
        chk("rst_start_a", 32'(a_start), 32'd0);
        chk("rst_data_a", 32'(a_txd), 32'd0);
        chk("rst_gid_a", 32'(a_gid), 32'd0);
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_busy_b", 32'(b_busy), 32'd0);
        chk("rst_start_b", 32'(b_start), 32'd0);

        // First frame from requester 0, then the idle gap.
        @(negedge clk);
        rst    = 1'b0;
        a_data = 32'h000000A5;
        #1;
        chk("t1_ready", 32'(a_ready), 32'h1);
        @(negedge clk);
        a_valid = '0;
        #1;
        chk("t1_start", 32'(a_start), 32'd1);
        chk("t1_data", 32'(a_txd), 32'hA5);
        chk("t1_gid", 32'(a_gid), 32'd0);
        chk("t1_busy", 32'(a_busy), 32'd1);
        chk("t1_ready_low", 32'(a_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("t1_start_low", 32'(a_start), 32'd0);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        a_valid = 4'h1;
        #1;
        chk("gap_busy", 32'(a_busy), 32'd1);
        chk("gap_ready0", 32'(a_ready), 32'd0);
        repeat (8) tick_pulse();
        @(negedge clk);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick_pulse();
            #1;
            if (i < 7) chk("gap_hold", 32'(a_ready), 32'd0);
        end
        chk("gap_end_ready", 32'(a_ready), 32'h1);
        chk("gap_end_busy", 32'(a_busy), 32'd0);

        // Done during START must be ignored; WAIT ignores ticks.
        @(negedge clk);
        a_valid = '0;
        a_done  = 1'b1;
        #1;
        chk("t6_start", 32'(a_start), 32'd1);
        @(negedge clk);
        a_done = 1'b0;
        #1;
        chk("t6_wait_busy", 32'(a_busy), 32'd1);
        repeat (16) tick_pulse();
        #1;
        chk("t6_still_wait", 32'(a_busy), 32'd1);

        // Reset in WAIT drops the frame and restores priority.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_data", 32'(a_txd), 32'd0);
        chk("t5_gid", 32'(a_gid), 32'd0);
        chk("t5_start", 32'(a_start), 32'd0);
        @(negedge clk);
        a_done = 1'b1;
        @(negedge clk);
        a_done = 1'b0;
        #1;
        chk("t5_late_done", 32'(a_busy), 32'd0);
        chk("t5_no_start", 32'(a_start), 32'd0);
        @(negedge clk);
        a_valid = 4'h3;
        a_data  = 32'h00002277;
        #1;
        chk("t5_prio", 32'(a_ready), 32'h1);
        @(negedge clk);
        a_valid = '0;
        #1;
        chk("t5_gid0", 32'(a_gid), 32'd0);
        chk("t5_data77", 32'(a_txd), 32'h77);
        finish_a();

        a_data = 32'h13121110;
        for (int i = 0; i < 21; i++) begin
            frame(tbl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
